// File: rtl/spart_drv_pkg.sv
// Shared definitions for the SPART bus driver: bus addresses, FSM states,
// and the elaboration-time baud divisor calculation.
package spart_drv_pkg;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    typedef enum logic [2:0] {
        SYNC,
        WR_DBL,
        WR_DBH,
        POLL,
        RD_RX,
        WR_TX
    } drv_state_e;

    // Rounded divisor for rate index n (4800 * 2^n baud).
    function automatic longint unsigned baud_div(
        input longint unsigned clk_hz,
        input longint unsigned sample_rate,
        input int unsigned     n
    );
        longint unsigned den;
        den = sample_rate * 64'd4800 * (64'd1 << n);
        return (clk_hz + den / 64'd2) / den;
    endfunction

endpackage

// File: rtl/spart_drv_fifo.sv
// Synchronous FIFO holding received bytes until they can be echoed.
// Push when full and pop when empty are ignored.
module spart_drv_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage array write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Next pointer/occupancy values; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/spart_bus_driver.sv
// Processor-side bus master for a SPART: programs the baud divisor from
// br_cfg (again whenever br_cfg changes) and echoes received bytes back
// through a FIFO. Define SPART_DRV_UPCASE_EN to fold ASCII lowercase to
// uppercase on the way into the FIFO.
module spart_bus_driver
    import spart_drv_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned SAMPLE_RATE = 10,
    parameter int unsigned BR_CFG_W    = 2,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BR_CFG_W-1:0]           br_cfg,
    input  logic                          rda,
    input  logic                          tbr,
    output logic                          iocs,
    output logic                          iorw,
    output logic [1:0]                    ioaddr,
    inout  logic [7:0]                    databus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int unsigned NUM_RATES = 1 << BR_CFG_W;

    if (BR_CFG_W < 2 || BR_CFG_W > 3) begin : g_bad_brw
        $error("spart_bus_driver: BR_CFG_W must be 2..3");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("spart_bus_driver: FIFO_DEPTH must be a power of two in 2..64");
    end

    logic [15:0] div_tbl [NUM_RATES];

    for (genvar gi = 0; gi < NUM_RATES; gi++) begin : g_div
        localparam longint unsigned DIV =
            baud_div(64'(CLK_FREQ_HZ), 64'(SAMPLE_RATE), gi);
        if (DIV == 64'd0 || DIV > 64'hFFFF) begin : g_bad_div
            $error("spart_bus_driver: baud divisor out of 16-bit range");
        end
        assign div_tbl[gi] = DIV[15:0];
    end

    drv_state_e           state_q, state_d;
    logic                 sync_cnt_q, sync_cnt_d;
    logic [BR_CFG_W-1:0]  sync1_q, sync2_q;
    logic [BR_CFG_W-1:0]  br_cur_q, br_cur_d;
    logic                 overflow_q, overflow_d;

    logic                 bus_oe;
    logic [7:0]           bus_dout;
    logic [7:0]           push_data;
    logic                 fifo_push, fifo_pop;
    logic                 fifo_full, fifo_empty;
    logic [7:0]           fifo_head;

    assign databus  = bus_oe ? bus_dout : 'z;
    assign overflow = overflow_q;

    // Two-flop synchroniser for the asynchronous br_cfg switches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= br_cfg;
            sync2_q <= sync1_q;
        end
    end

    // Byte captured from the bus in RD_RX, optionally case-folded.
    always_comb begin
        push_data = databus;
`ifdef SPART_DRV_UPCASE_EN
        if (databus >= 8'h61 && databus <= 8'h7A) begin
            push_data[5] = 1'b0;
        end
`endif
    end

    // FSM next-state and bus outputs; each access lasts exactly one cycle.
    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        br_cur_d   = br_cur_q;
        overflow_d = overflow_q;
        iocs       = 1'b0;
        iorw       = 1'b1;
        ioaddr     = ADDR_BUF;
        bus_oe     = 1'b0;
        bus_dout   = '0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        case (state_q)
            SYNC: begin
                sync_cnt_d = 1'b1;
                if (sync_cnt_q) begin
                    sync_cnt_d = 1'b0;
                    state_d    = WR_DBL;
                end
            end
            WR_DBL: begin
                iocs     = 1'b1;
                iorw     = 1'b0;
                ioaddr   = ADDR_DBL;
                bus_oe   = 1'b1;
                bus_dout = div_tbl[sync2_q][7:0];
                br_cur_d = sync2_q;
                state_d  = WR_DBH;
            end
            WR_DBH: begin
                iocs     = 1'b1;
                iorw     = 1'b0;
                ioaddr   = ADDR_DBH;
                bus_oe   = 1'b1;
                bus_dout = div_tbl[br_cur_q][15:8];
                state_d  = POLL;
            end
            POLL: begin
                if (sync2_q != br_cur_q) begin
                    state_d = WR_DBL;
                end else if (rda) begin
                    state_d = RD_RX;
                end else if (tbr && !fifo_empty) begin
                    state_d = WR_TX;
                end
            end
            RD_RX: begin
                iocs   = 1'b1;
                iorw   = 1'b1;
                ioaddr = ADDR_BUF;
                if (fifo_full) begin
                    overflow_d = 1'b1;
                end else begin
                    fifo_push = 1'b1;
                end
                state_d = POLL;
            end
            WR_TX: begin
                iocs     = 1'b1;
                iorw     = 1'b0;
                ioaddr   = ADDR_BUF;
                bus_oe   = 1'b1;
                bus_dout = fifo_head;
                fifo_pop = 1'b1;
                state_d  = POLL;
            end
            default: state_d = SYNC;
        endcase
    end

    // FSM state, programmed rate and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SYNC;
            sync_cnt_q <= 1'b0;
            br_cur_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            br_cur_q   <= br_cur_d;
            overflow_q <= overflow_d;
        end
    end

    spart_drv_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (push_data),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_spart_bus_driver.sv
// Directed bench for spart_bus_driver with a minimal SPART bus model:
// the bench drives rx_byte onto databus during reads, and a pullup makes
// an undriven bus read as 0xFF.
module tb_spart_bus_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  br_cfg;
    logic        rda;
    logic        tbr;
    logic        iocs;
    logic        iorw;
    logic [1:0]  ioaddr;
    wire logic [7:0] databus;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic [7:0]  rx_byte;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    assign databus = (iocs && iorw) ? rx_byte : 8'hzz;

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (databus[g]);
    end

    spart_bus_driver #(
        .CLK_FREQ_HZ (50_000_000),
        .SAMPLE_RATE (10),
        .BR_CFG_W    (2),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .br_cfg     (br_cfg),
        .rda        (rda),
        .tbr        (tbr),
        .iocs       (iocs),
        .iorw       (iorw),
        .ioaddr     (ioaddr),
        .databus    (databus),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    // Stimulus: offer one byte via rda and wait for the driver to read it.
    task automatic send_rx(input logic [7:0] b, output bit ok);
        rx_byte = b;
        rda     = 1'b1;
        ok      = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (iocs && iorw && ioaddr == 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        rda = 1'b0;
        @(negedge clk);
    endtask

    // Stimulus: wait for the next transmit-buffer write and capture its byte.
    task automatic get_tx(output logic [7:0] b, output bit ok);
        ok = 1'b0;
        b  = 8'h00;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (iocs && !iorw && ioaddr == 2'b00) begin
                ok = 1'b1;
                b  = databus;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; br_cfg = 2'b00; rda = 1'b0; tbr = 1'b0; rx_byte = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++; if (iocs !== 1'b0) begin n_err++; $display("FAIL rst_iocs: got %b exp 0", iocs); end
        n_cmp++; if (iorw !== 1'b1) begin n_err++; $display("FAIL rst_iorw: got %b exp 1", iorw); end
        n_cmp++; if (ioaddr !== 2'b00) begin n_err++; $display("FAIL rst_ioaddr: got %b exp 00", ioaddr); end
        n_cmp++; if (databus !== 8'hFF) begin n_err++; $display("FAIL rst_databus: got %h exp ff (released)", databus); end
        n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL rst_count: got %0d exp 0", fifo_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b exp 0", overflow); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (iocs !== 1'b0) begin n_err++; $display("FAIL sync_iocs: got %b exp 0", iocs); end
        @(negedge clk);
        n_cmp++; if ({iocs, iorw, ioaddr} !== 4'b1010) begin n_err++; $display("FAIL dbl_ctrl: got %b exp 1010", {iocs, iorw, ioaddr}); end
        n_cmp++; if (databus !== 8'h12) begin n_err++; $display("FAIL dbl_data: got %h exp 12", databus); end
        @(negedge clk);
        n_cmp++; if ({iocs, iorw, ioaddr} !== 4'b1011) begin n_err++; $display("FAIL dbh_ctrl: got %b exp 1011", {iocs, iorw, ioaddr}); end
        n_cmp++; if (databus !== 8'h04) begin n_err++; $display("FAIL dbh_data: got %h exp 04", databus); end
        @(negedge clk);
        n_cmp++; if (iocs !== 1'b0) begin n_err++; $display("FAIL post_prog_iocs: got %b exp 0", iocs); end
    endtask

    task automatic test_reprogram();
        int lat;
        lat = 0;
        repeat (3) @(negedge clk);
        br_cfg = 2'b11;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (iocs) begin
                lat = k;
                break;
            end
        end
        n_cmp++; if (lat == 0 || lat > 4) begin n_err++; $display("FAIL reprog_latency: got %0d cycles exp 1..4", lat); end
        n_cmp++; if ({iorw, ioaddr} !== 3'b010 || databus !== 8'h82) begin n_err++; $display("FAIL reprog_dbl: got rw/addr %b data %h exp 010 82", {iorw, ioaddr}, databus); end
        @(negedge clk);
        n_cmp++; if ({iocs, iorw, ioaddr} !== 4'b1011 || databus !== 8'h00) begin n_err++; $display("FAIL reprog_dbh: got ctrl %b data %h exp 1011 00", {iocs, iorw, ioaddr}, databus); end
        @(negedge clk);
        n_cmp++; if (iocs !== 1'b0) begin n_err++; $display("FAIL reprog_end: got iocs %b exp 0", iocs); end
        br_cfg = 2'b00;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (iocs) begin
                lat = k;
                break;
            end
        end
        n_cmp++; if (lat == 0 || ioaddr !== 2'b10 || databus !== 8'h12) begin n_err++; $display("FAIL reprog_back: got lat %0d addr %b data %h exp addr 10 data 12", lat, ioaddr, databus); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_echo();
        bit seen;
        seen = 1'b0;
        tbr = 1'b1; rx_byte = 8'h41; rda = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (iocs && iorw && ioaddr == 2'b00) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL echo_read: got no read exp RD_RX"); end
        n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL echo_cnt0: got %0d exp 0", fifo_count); end
        rda = 1'b0;
        @(negedge clk);
        n_cmp++; if (fifo_count !== 4'd1 || iocs !== 1'b0) begin n_err++; $display("FAIL echo_cnt1: got cnt %0d iocs %b exp 1 0", fifo_count, iocs); end
        @(negedge clk);
        n_cmp++; if ({iocs, iorw, ioaddr} !== 4'b1000 || databus !== 8'h41) begin n_err++; $display("FAIL echo_tx: got ctrl %b data %h exp 1000 41", {iocs, iorw, ioaddr}, databus); end
        @(negedge clk);
        n_cmp++; if (fifo_count !== 4'd0 || iocs !== 1'b0) begin n_err++; $display("FAIL echo_cnt_end: got cnt %0d iocs %b exp 0 0", fifo_count, iocs); end
        tbr = 1'b0;
    endtask

    task automatic test_overflow();
        bit ok;
        logic [7:0] b;
        int extra;
        tbr = 1'b0;
        for (int i = 0; i < 9; i++) begin
            send_rx(8'h30 + 8'(i), ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL ovf_read%0d: got no read exp read", i); end
            if (i == 7) begin
                n_cmp++; if (fifo_count !== 4'd8 || overflow !== 1'b0) begin n_err++; $display("FAIL ovf_full: got cnt %0d ovf %b exp 8 0", fifo_count, overflow); end
            end
        end
        n_cmp++; if (fifo_count !== 4'd8 || overflow !== 1'b1) begin n_err++; $display("FAIL ovf_drop: got cnt %0d ovf %b exp 8 1", fifo_count, overflow); end
        tbr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            get_tx(b, ok);
            n_cmp++; if (!ok || b !== 8'h30 + 8'(i)) begin n_err++; $display("FAIL ovf_tx%0d: got ok %b byte %h exp %h", i, ok, b, 8'h30 + 8'(i)); end
        end
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (iocs) extra++;
        end
        n_cmp++; if (extra != 0) begin n_err++; $display("FAIL ovf_extra: got %0d accesses exp 0", extra); end
        n_cmp++; if (fifo_count !== 4'd0 || overflow !== 1'b1) begin n_err++; $display("FAIL ovf_after: got cnt %0d ovf %b exp 0 1", fifo_count, overflow); end
        tbr = 1'b0;
    endtask

    task automatic test_upcase();
        bit ok;
        logic [7:0] b;
        logic [7:0] in_b  [3];
        logic [7:0] exp_b [3];
        in_b[0] = 8'h61; in_b[1] = 8'h7B; in_b[2] = 8'h5A;
`ifdef SPART_DRV_UPCASE_EN
        exp_b[0] = 8'h41; exp_b[1] = 8'h7B; exp_b[2] = 8'h5A;
`else
        exp_b[0] = 8'h61; exp_b[1] = 8'h7B; exp_b[2] = 8'h5A;
`endif
        tbr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_rx(in_b[i], ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL case_read%0d: got no read exp read", i); end
        end
        tbr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            get_tx(b, ok);
            n_cmp++; if (!ok || b !== exp_b[i]) begin n_err++; $display("FAIL case_tx%0d: got ok %b byte %h exp %h", i, ok, b, exp_b[i]); end
        end
        tbr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rst_mid();
        bit ok;
        bit seen;
        tbr = 1'b0;
        send_rx(8'h11, ok);
        send_rx(8'h22, ok);
        send_rx(8'h33, ok);
        n_cmp++; if (fifo_count !== 4'd3) begin n_err++; $display("FAIL mid_fill: got %0d exp 3", fifo_count); end
        tbr = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (iocs && !iorw && ioaddr == 2'b00) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL mid_wrtx: got no WR_TX exp one"); end
        rst = 1'b1;
        #1;
        n_cmp++; if (iocs !== 1'b0 || databus !== 8'hFF) begin n_err++; $display("FAIL mid_abort: got iocs %b data %h exp 0 ff", iocs, databus); end
        n_cmp++; if (fifo_count !== 4'd0 || overflow !== 1'b0) begin n_err++; $display("FAIL mid_clear: got cnt %0d ovf %b exp 0 0", fifo_count, overflow); end
        tbr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (iocs !== 1'b0) begin n_err++; $display("FAIL mid_sync: got iocs %b exp 0", iocs); end
        @(negedge clk);
        n_cmp++; if ({iocs, iorw, ioaddr} !== 4'b1010 || databus !== 8'h12) begin n_err++; $display("FAIL mid_dbl: got ctrl %b data %h exp 1010 12", {iocs, iorw, ioaddr}, databus); end
        @(negedge clk);
        n_cmp++; if ({iocs, iorw, ioaddr} !== 4'b1011 || databus !== 8'h04) begin n_err++; $display("FAIL mid_dbh: got ctrl %b data %h exp 1011 04", {iocs, iorw, ioaddr}, databus); end
    endtask

    initial begin
        test_reset();
        test_reprogram();
        test_echo();
        test_overflow();
        test_upcase();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spart_bus_driver.md
Name: spart_bus_driver

Overview:
- Parametrised bus master for the SPART processor-side interface (iocs/iorw/ioaddr/8-bit databus).
- After reset it programs the baud divisor from br_cfg, then runs a buffered echo loop: received bytes are read out, queued in a FIFO, and written back to the transmit buffer when tbr allows.
- It reprograms the divisor whenever br_cfg changes at runtime.
- Sits between board switches (br_cfg) and the SPART instance at top level.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency.
- SAMPLE_RATE, 10, SPART clocks-per-bit prescale factor.
- BR_CFG_W, 2, width of br_cfg; legal 2..3. Rate index n selects 4800*2^n baud.
- FIFO_DEPTH, 8, echo FIFO entries; power of two, 2..64.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- br_cfg  input  BR_CFG_W  baud select; asynchronous to clk
- rda  input  1  SPART receive data available
- tbr  input  1  SPART transmit buffer ready
- iocs  output  1  SPART chip select; one bus access per cycle where high
- iorw  output  1  1 = read, 0 = write
- ioaddr  output  2  00 = TX/RX buffer, 01 = status, 10 = DB low, 11 = DB high
- databus  inout  8  driven only when iocs=1 and iorw=0; otherwise high-Z
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  output  1  sticky; set on drop of a received byte

Behaviour:
- Reset values: iocs=0, iorw=1, ioaddr=00, databus=Z, fifo_count=0, overflow=0, state=SYNC. Reset mid-access aborts the access immediately.
- Divisor computation:
  - divisor(n) = round(CLK_FREQ_HZ / (SAMPLE_RATE * 4800 * 2^n)), 16 bits, computed at elaboration.
  - Defaults: n=0 -> 0x0412, n=1 -> 0x0209, n=2 -> 0x0104, n=3 -> 0x0082.
  - Elaboration error if any entry is 0 or exceeds 0xFFFF.
- br_cfg synchronisation: 2-flop synchroniser. br_cur holds the value last programmed.
- FSM states: SYNC, WR_DBL, WR_DBH, POLL, RD_RX, WR_TX.
  - SYNC: 2 cycles with iocs=0 (fills synchroniser) -> WR_DBL. First iocs pulse occurs in the 3rd cycle after rst deasserts.
  - WR_DBL: iocs=1, iorw=0, ioaddr=10, databus=div[7:0]; latch br_cur -> WR_DBH.
  - WR_DBH: ioaddr=10→11, databus=div[15:8] -> POLL.
  - POLL: iocs=0. Priority order:
    - synced br_cfg != br_cur -> WR_DBL;
    - else rda=1 -> RD_RX;
    - else tbr=1 and FIFO non-empty -> WR_TX;
    - else stay.
  - RD_RX: iocs=1, iorw=1, ioaddr=00. databus is sampled at the end of this cycle and pushed into the FIFO -> POLL.
  - WR_TX: iocs=1, iorw=0, ioaddr=00, databus = FIFO head, popped this cycle -> POLL.
- Each access is exactly 1 cycle; at least one POLL cycle separates accesses, giving SPART status time to update.
- Receive priority over transmit avoids SPART receive overrun.
- FIFO full on RD_RX: the read still occurs (clears rda), the byte is discarded, overflow is set, and fifo_count is unchanged. overflow clears only on rst.
- Push and pop never occur in the same cycle (mutually exclusive states). Pointers wrap modulo FIFO_DEPTH.
- A br_cfg change during RD_RX/WR_TX completes the current access first. FIFO contents are preserved across reprogramming.
- br_cfg glitches shorter than 2 cycles may be missed; this is acceptable.

Optional Feature:
- Macro: SPART_DRV_UPCASE_EN.
- Defined: bytes 0x61..0x7A have bit 5 cleared on push (lowercase echoed as uppercase); all other bytes pass unchanged. Adds no latency.
- Undefined: bytes are echoed verbatim.

Decomposition:
- Package spart_drv_pkg:
  - ioaddr localparams (ADDR_BUF, ADDR_STAT, ADDR_DBL, ADDR_DBH);
  - state enum typedef;
  - constant function baud_div(clk_hz, sample_rate, n).
- Sub-module spart_drv_fifo: synchronous FIFO with push/pop/full/empty/count, parametrised WIDTH=8 and DEPTH.

Test Plan:
- Reset release with br_cfg=00 -> 3rd cycle: iocs=1, iorw=0, ioaddr=10, databus=0x12; next cycle: ioaddr=11, databus=0x04; then iocs=0.
- br_cfg changes 00->11 while idle -> within 4 cycles, writes 0x82 then 0x00 to DB low/high; no other access in between.
- SPART model asserts rda with byte 0x41, tbr=1 -> RD_RX read, then WR_TX writes 0x41 at ioaddr=00; fifo_count goes 0->1->0.
- tbr=0, 9 received bytes with FIFO_DEPTH=8 -> fifo_count=8, overflow=1, 9th byte lost. Raise tbr -> 8 bytes transmitted in order.
- With SPART_DRV_UPCASE_EN, receive 0x61, 0x7B, 0x5A -> transmits 0x41, 0x7B, 0x5A. Without the macro -> transmits 0x61, 0x7B, 0x5A.
- Assert rst during WR_TX with FIFO holding 3 bytes -> iocs=0 and databus=Z in the same cycle; fifo_count=0; divisor is reprogrammed after release.
